// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiplies by shift-add and divides by restoring division, one bit per clock.
// A single 64-bit accumulator is shared by both datapaths:
//   multiply: {partial product high, multiplier shifting out}
//   divide:   {partial remainder, dividend shifting out / quotient shifting in}
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operandA,
    input  logic [XLEN-1:0] operandB,
    input  logic [4:0]      rdIn,
    output logic            busy,
    output logic            done,
    output logic            writeRegister,
    output logic [4:0]      rdOut,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH,
        S_SPECIAL
    } state_t;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [2:0]        op;
    logic [4:0]        rd_q;
    logic [5:0]        cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic              neg_q;
    logic              neg_r;

    logic              a_sgn;
    logic              b_sgn;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fin_val;

    // Operand decode at issue and per-iteration datapath arithmetic
    always_comb begin
        a_sgn    = 1'b0;
        b_sgn    = 1'b0;
        if (funct3[2]) begin
            a_sgn = ~funct3[0];
            b_sgn = ~funct3[0];
        end else begin
            a_sgn = ~(funct3[1] & funct3[0]);
            b_sgn = ~funct3[1];
        end
        a_neg    = a_sgn & operandA[XLEN-1];
        b_neg    = b_sgn & operandB[XLEN-1];
        mag_a    = a_neg ? -operandA : operandA;
        mag_b    = b_neg ? -operandB : operandB;
        div_zero = (operandB == '0);
        div_ovf  = ~funct3[0] & (operandA == MIN_INT) & (operandB == '1);

        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        // Shifted partial remainder is always < 2*divisor, so bit XLEN is the borrow
        div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};

        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

        fin_val  = '0;
        if (op[2])
            fin_val = op[1] ? rem_fix : quo_fix;
        else if (op[1:0] == 2'b00)
            fin_val = prod_fix[XLEN-1:0];
        else
            fin_val = prod_fix[2*XLEN-1:XLEN];
    end

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            op            <= '0;
            rd_q          <= '0;
            cnt           <= '0;
            acc           <= '0;
            opnd          <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            writeRegister <= 1'b0;
            rdOut         <= '0;
            result        <= '0;
        end else begin
            done          <= 1'b0;
            writeRegister <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op    <= funct3;
                        rd_q  <= rdIn;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        if (funct3[2] && div_zero) begin
                            acc   <= {{XLEN{1'b0}}, (funct3[1] ? operandA : '1)};
                            state <= S_SPECIAL;
                        end else if (funct3[2] && div_ovf) begin
                            acc   <= {{XLEN{1'b0}}, (funct3[1] ? '0 : MIN_INT)};
                            state <= S_SPECIAL;
                        end else if (funct3[2]) begin
                            acc   <= {{XLEN{1'b0}}, mag_a};
                            opnd  <= mag_b;
                            state <= S_RUN;
                        end else begin
                            acc   <= {{XLEN{1'b0}}, mag_b};
                            opnd  <= mag_a;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (op[2]) begin
                        if (div_diff[XLEN])
                            acc <= {acc[2*XLEN-2:0], 1'b0};
                        else
                            acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                    end else begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(XLEN-1))
                        state <= S_FINISH;
                end
                S_FINISH: begin
                    result        <= fin_val;
                    rdOut         <= rd_q;
                    done          <= 1'b1;
                    writeRegister <= 1'b1;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
                S_SPECIAL: begin
                    result        <= acc[XLEN-1:0];
                    rdOut         <= rd_q;
                    done          <= 1'b1;
                    writeRegister <= 1'b1;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits between the register file read ports (operandA = registerRead1, operandB = registerRead2) and the register file write port (result → dataToWrite, writeRegister, rdOut → rd).
- Multiplies and divides on shift/add or restore datapaths, one bit per cycle.
- Returns the result with a single-cycle writeback pulse and holds off the issuing stage with busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported and verified.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  issue request; sampled only in IDLE
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operandA  input  XLEN  rs1 value (multiplicand/dividend)
- operandB  input  XLEN  rs2 value (multiplier/divisor)
- rdIn  input  5  destination register of the issued op
- busy  output  1  high while an accepted op is in flight
- done  output  1  one-cycle completion pulse
- writeRegister  output  1  equals done; drives register file write enable
- rdOut  output  5  destination register, valid while done
- result  output  XLEN  result value, valid while done, held until the next completion

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is asynchronous and active-high. While reset is high, all of these are 0: state=IDLE, busy, done, writeRegister, rdOut, result, and all internal accumulators and counters.
- States:
  - IDLE: start=1 at an edge latches funct3, operands and rdIn. The next state is SPECIAL if a special case applies, otherwise RUN. busy=1 from that edge.
  - RUN: 32 iterations, one per edge. A 6-bit counter runs 0..31. After the 32nd iteration edge the state goes to FINISH.
  - FINISH: one edge applies sign fixup and upper/lower select, registers result, sets done=1 and busy=0, and returns to IDLE.
  - SPECIAL: one edge registers the special-case result, sets done=1 and busy=0, and returns to IDLE.
- Latency:
  - Normal op: start accepted at edge E0; done high in the cycle after E33; done low after E34 unless another op completes then.
  - Special case: done high in the cycle after E1.
- Handshake:
  - start while busy=1 is ignored; no queueing.
  - start is accepted in the cycle done is high, since the state is already IDLE.
  - done/writeRegister is exactly one cycle per accepted op.
  - rdOut is emitted unchanged, including x0; the register file discards writes to x0.
- Multiply:
  - Operate on magnitudes. MUL and MULH treat both operands as signed. MULHSU treats A as signed and B as unsigned. MULHU treats both as unsigned.
  - Shift-add into a 64-bit product register.
  - Negate the 64-bit product when exactly one signed operand is negative.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide:
  - Restoring division on magnitudes. DIV and REM are signed; DIVU and REMU are unsigned.
  - Quotient is negated when the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Special cases (SPECIAL state, checked at acceptance):
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
  - Multiplies never take SPECIAL.
- Operand capture: operands are sampled only at acceptance. Input changes while busy have no effect.
- Reset mid-operation: the op is discarded, outputs go to 0 immediately (asynchronously), and no done pulse follows. After deassertion the unit is in IDLE and accepts start at the next edge.

Test Plan:
1. MUL 7 × 0xFFFFFFFD (−3), rdIn=5 → busy for 33 cycles; single done pulse with result=0xFFFFFFEB, rdOut=5, writeRegister=1.
2. High multiplies:
   - MULH 0x80000000 × 0x80000000 → 0x40000000
   - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE
   - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF
3. Divides:
   - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD
   - REM → 0xFFFFFFFF
   - DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF
   - REMU 100 / 7 → 2
4. Special cases, each with done on the cycle after E1:
   - DIV 5/0 → 0xFFFFFFFF
   - REMU 5/0 → 5
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000
   - REM of the same → 0
5. Handshake: start pulsed at iteration 10 of a MUL → ignored, original result unchanged. A new start asserted in the done cycle → accepted; second done exactly 34 cycles after the first.
6. Reset mid-op: assert reset asynchronously (between edges) at iteration 10 of a DIV → busy, done and result 0 immediately; no done after release; a subsequent MUL 3×4 → result 12.
